// File: rtl/vpu_pkg.sv
// Shared definitions for the bf16 max/min reduction block.
//   OPERAND_WIDTH  : width of one bf16 element
//   BF16_*         : identity and canonical NaN encodings
//   red_state_e    : reduction FSM state encoding
//   bf16_order_key : maps a bf16 pattern onto an unsigned key whose natural
//                    order is the sign-magnitude order (+0 ranks above -0)
//   bf16_is_nan    : exponent all-ones with a non-zero mantissa
package vpu_pkg;

    localparam int          OPERAND_WIDTH = 16;
    localparam logic [15:0] BF16_NEG_INF  = 16'hFF80;
    localparam logic [15:0] BF16_POS_INF  = 16'h7F80;
    localparam logic [15:0] BF16_QNAN     = 16'h7FC0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } red_state_e;

    // Positive values get the top bit set so they sort above all negatives;
    // negatives are inverted so a larger magnitude gives a smaller key.
    // -0 (0x8000) maps to 0x7FFF, just below +0 at 0x8000.
    function automatic logic [15:0] bf16_order_key(input logic [15:0] x);
        return x[15] ? ~x : {1'b1, x[14:0]};
    endfunction

    function automatic logic bf16_is_nan(input logic [15:0] x);
        return (x[14:7] == 8'hFF) && (x[6:0] != 7'd0);
    endfunction

endpackage

// File: rtl/vpu_fp_cmp_sel.sv
// Two-operand bf16 winner select, used for every lane-tree node and for the
// accumulator merge.
//   mode        : 0 = keep the larger value, 1 = keep the smaller value
//   a_* / b_*   : value, index and valid of each candidate; the caller always
//                 wires the lower-index candidate to a, so a tie keeps a
//   y_*         : winning value/index; y_vld is set when either input is valid
// Optional macro VPU_FP_MAX_REDUCE_NAN_EN: a valid NaN wins regardless of mode,
// with a preferred over b so the first NaN in index order survives.
module vpu_fp_cmp_sel
    import vpu_pkg::*;
#(
    parameter int IDX_W = 2
) (
    input  logic                     mode,
    input  logic [OPERAND_WIDTH-1:0] a_val,
    input  logic [IDX_W-1:0]         a_idx,
    input  logic                     a_vld,
    input  logic [OPERAND_WIDTH-1:0] b_val,
    input  logic [IDX_W-1:0]         b_idx,
    input  logic                     b_vld,
    output logic [OPERAND_WIDTH-1:0] y_val,
    output logic [IDX_W-1:0]         y_idx,
    output logic                     y_vld
);

    logic [OPERAND_WIDTH-1:0] a_key;
    logic [OPERAND_WIDTH-1:0] b_key;
    logic                     b_better;
    logic                     pick_b;

    assign a_key    = bf16_order_key(a_val);
    assign b_key    = bf16_order_key(b_val);
    // Strict comparison: equal keys never displace a.
    assign b_better = mode ? (b_key < a_key) : (b_key > a_key);

`ifdef VPU_FP_MAX_REDUCE_NAN_EN
    logic a_nan;
    logic b_nan;
    assign a_nan = bf16_is_nan(a_val);
    assign b_nan = bf16_is_nan(b_val);
`endif

    always_comb begin
        pick_b = 1'b0;
        if (!a_vld) begin
            pick_b = b_vld;
        end else if (b_vld) begin
`ifdef VPU_FP_MAX_REDUCE_NAN_EN
            if (a_nan)      pick_b = 1'b0;
            else if (b_nan) pick_b = 1'b1;
            else            pick_b = b_better;
`else
            pick_b = b_better;
`endif
        end
    end

    assign y_val = pick_b ? b_val : a_val;
    assign y_idx = pick_b ? b_idx : a_idx;
    assign y_vld = a_vld | b_vld;

endmodule

// File: rtl/vpu_fp_max_reduce.sv
// Streaming bf16 max/min reduction with winner index.
// Each accepted beat carries LANES bf16 elements with a per-lane valid mask.
// Stage 1 registers the lane-tree winner of the beat; stage 2 merges it into
// the running accumulator. The result is presented two edges after the last
// beat is accepted and held until out_ready.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : beat handshake
//   in_data               : LANES bf16 elements, lane 0 in the LSBs
//   in_mask               : per-lane element valid
//   in_last               : final beat of the reduction
//   in_mode               : 0 = max, 1 = min (taken from the first beat only)
//   out_valid/out_ready   : result handshake
//   out_data, out_idx     : winning value and its global index beat*LANES+lane
//   out_empty             : no valid element was seen (out_data is the identity)
//   out_ovf               : more than MAX_BEATS beats were accepted
// Optional macro VPU_FP_MAX_REDUCE_NAN_EN: any valid NaN forces out_data to the
// canonical quiet NaN and out_idx to the first NaN's index.
module vpu_fp_max_reduce
    import vpu_pkg::*;
#(
    parameter int LANES     = 4,
    parameter int MAX_BEATS = 64,
    parameter int IDX_W     = $clog2(LANES * MAX_BEATS)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [LANES*OPERAND_WIDTH-1:0] in_data,
    input  logic [LANES-1:0]               in_mask,
    input  logic                           in_last,
    input  logic                           in_mode,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [OPERAND_WIDTH-1:0]       out_data,
    output logic [IDX_W-1:0]               out_idx,
    output logic                           out_empty,
    output logic                           out_ovf
);

    localparam int LANE_W = $clog2(LANES);
    localparam int CNT_W  = $clog2(MAX_BEATS + 1);
    localparam int NODES  = 2 * LANES - 1;

    red_state_e state_reg, state_next;

    logic                     ready_en_reg;
    logic                     accept;
    logic                     mode_reg;
    logic                     beat_mode;
    logic [CNT_W-1:0]         cnt_reg;
    logic [CNT_W-1:0]         cur_beat;
    logic                     beat_sat;
    logic                     ovf_reg;
    logic [IDX_W-1:0]         beat_idx;

    logic                     s1_valid_reg;
    logic                     s1_first_reg;
    logic [OPERAND_WIDTH-1:0] s1_val_reg;
    logic [IDX_W-1:0]         s1_idx_reg;
    logic                     s1_any_reg;

    logic [OPERAND_WIDTH-1:0] acc_val_reg;
    logic [IDX_W-1:0]         acc_idx_reg;
    logic                     acc_any_reg;
    logic [OPERAND_WIDTH-1:0] merge_val;
    logic [IDX_W-1:0]         merge_idx;
    logic                     merge_vld;
    logic [OPERAND_WIDTH-1:0] result_val;

    logic                     out_valid_reg;
    logic [OPERAND_WIDTH-1:0] out_data_reg;
    logic [IDX_W-1:0]         out_idx_reg;
    logic                     out_empty_reg;
    logic                     out_ovf_reg;

    // ------------------------------------------------------------------
    // Lane tree, heap-ordered: node i has children 2i+1 (lower lanes) and
    // 2i+2, leaves sit at LANES-1+lane, the beat winner ends up at node 0.
    // ------------------------------------------------------------------
    logic [OPERAND_WIDTH-1:0] node_val [NODES];
    logic [LANE_W-1:0]        node_idx [NODES];
    logic                     node_vld [NODES];

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_leaf
            assign node_val[LANES-1+gi] = in_data[gi*OPERAND_WIDTH +: OPERAND_WIDTH];
            assign node_idx[LANES-1+gi] = LANE_W'(gi);
            assign node_vld[LANES-1+gi] = in_mask[gi];
        end
        for (genvar gi = 0; gi < LANES - 1; gi++) begin : g_node
            vpu_fp_cmp_sel #(.IDX_W(LANE_W)) u_cmp (
                .mode  (beat_mode),
                .a_val (node_val[2*gi+1]),
                .a_idx (node_idx[2*gi+1]),
                .a_vld (node_vld[2*gi+1]),
                .b_val (node_val[2*gi+2]),
                .b_idx (node_idx[2*gi+2]),
                .b_vld (node_vld[2*gi+2]),
                .y_val (node_val[gi]),
                .y_idx (node_idx[gi]),
                .y_vld (node_vld[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Beat bookkeeping. In IDLE the incoming beat is beat 0 of a new
    // reduction, so the counter and mode of the previous one are ignored.
    // ------------------------------------------------------------------
    assign accept    = in_valid && in_ready;
    assign cur_beat  = (state_reg == ST_IDLE) ? '0 : cnt_reg;
    assign beat_sat  = (cur_beat == CNT_W'(MAX_BEATS));
    assign beat_mode = (state_reg == ST_IDLE) ? in_mode : mode_reg;
    // Beats past the index range report an all-ones index.
    assign beat_idx  = beat_sat ? '1
                     : IDX_W'(cur_beat) * IDX_W'(LANES) + IDX_W'(node_idx[0]);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            ready_en_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ready_en_reg <= 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                in_ready = ready_en_reg;
                if (accept) state_next = in_last ? ST_DRAIN : ST_ACC;
            end
            ST_ACC: begin
                in_ready = ready_en_reg;
                if (accept && in_last) state_next = ST_DRAIN;
            end
            ST_DRAIN: state_next = ST_OUT;
            ST_OUT:   if (out_valid_reg && out_ready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Stage 1: register the beat winner and per-reduction state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_first_reg <= 1'b0;
            s1_val_reg   <= '0;
            s1_idx_reg   <= '0;
            s1_any_reg   <= 1'b0;
            mode_reg     <= 1'b0;
            cnt_reg      <= '0;
            ovf_reg      <= 1'b0;
        end else begin
            s1_valid_reg <= accept;
            if (accept) begin
                s1_first_reg <= (state_reg == ST_IDLE);
                s1_val_reg   <= node_val[0];
                s1_idx_reg   <= beat_idx;
                s1_any_reg   <= node_vld[0];
                mode_reg     <= beat_mode;
                cnt_reg      <= beat_sat ? cur_beat : cur_beat + 1'b1;
                ovf_reg      <= ((state_reg == ST_IDLE) ? 1'b0 : ovf_reg) | beat_sat;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: merge into the accumulator. On the first beat the old
    // accumulator is masked off so the beat winner (or identity) replaces it.
    // ------------------------------------------------------------------
    vpu_fp_cmp_sel #(.IDX_W(IDX_W)) u_merge (
        .mode  (mode_reg),
        .a_val (acc_val_reg),
        .a_idx (acc_idx_reg),
        .a_vld (acc_any_reg && !s1_first_reg),
        .b_val (s1_val_reg),
        .b_idx (s1_idx_reg),
        .b_vld (s1_any_reg),
        .y_val (merge_val),
        .y_idx (merge_idx),
        .y_vld (merge_vld)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_val_reg <= '0;
            acc_idx_reg <= '0;
            acc_any_reg <= 1'b0;
        end else if (s1_valid_reg) begin
            acc_any_reg <= merge_vld;
            acc_val_reg <= merge_vld ? merge_val
                         : (mode_reg ? BF16_POS_INF : BF16_NEG_INF);
            acc_idx_reg <= merge_vld ? merge_idx : '0;
        end
    end

`ifdef VPU_FP_MAX_REDUCE_NAN_EN
    assign result_val = (acc_any_reg && bf16_is_nan(acc_val_reg)) ? BF16_QNAN : acc_val_reg;
`else
    assign result_val = acc_val_reg;
`endif

    // ------------------------------------------------------------------
    // Output register: loaded on the first OUT cycle, then frozen until
    // the handshake.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_idx_reg   <= '0;
            out_empty_reg <= 1'b0;
            out_ovf_reg   <= 1'b0;
        end else if (state_reg == ST_OUT) begin
            if (!out_valid_reg) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= result_val;
                out_idx_reg   <= acc_idx_reg;
                out_empty_reg <= !acc_any_reg;
                out_ovf_reg   <= ovf_reg;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_idx   = out_idx_reg;
    assign out_empty = out_empty_reg;
    assign out_ovf   = out_ovf_reg;

endmodule

// File: tb/tb_vpu_fp_max_reduce.sv
// Self-checking bench for vpu_fp_max_reduce (LANES=4, MAX_BEATS=4).
// Directed scenarios use hand-computed constants; the randomized scenario
// compares against a reference model that ranks elements with signed integer
// arithmetic and scans them in global index order.
module tb_vpu_fp_max_reduce;

    localparam int LANES = 4;
    localparam int MAXB  = 4;
    localparam int IW    = 4;

    typedef struct packed {
        logic [15:0]   val;
        logic [IW-1:0] idx;
        logic          empty;
        logic          ovf;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [63:0]   in_data;
    logic [3:0]    in_mask;
    logic          in_last;
    logic          in_mode;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   out_data;
    logic [IW-1:0] out_idx;
    logic          out_empty;
    logic          out_ovf;

    int            n_cmp;
    int            n_err;
    logic [63:0]   beat_data [8];
    logic [3:0]    beat_mask [8];
    int            nbeats;
    logic          mode;
    logic          flip_mode;
    int            obs_lat;

    vpu_fp_max_reduce #(.LANES(LANES), .MAX_BEATS(MAXB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mask   (in_mask),
        .in_last   (in_last),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_empty (out_empty),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int rank(input logic [15:0] x);
        int mag;
        mag = int'(x[14:0]);
        return x[15] ? (-mag - 1) : mag;
    endfunction

    function automatic bit is_nan(input logic [15:0] x);
        return (x[14:7] == 8'hFF) && (x[6:0] != 0);
    endfunction

    function automatic exp_t model();
        exp_t e;
        bit   found;
        bit   nan_seen;
        int   best;
        e.val    = mode ? 16'h7F80 : 16'hFF80;
        e.idx    = '0;
        e.empty  = 1'b1;
        e.ovf    = (nbeats > MAXB);
        found    = 0;
        nan_seen = 0;
        best     = 0;
        for (int b = 0; b < nbeats; b++) begin
            for (int l = 0; l < LANES; l++) begin
                logic [15:0]   x;
                logic [IW-1:0] g;
                if (!beat_mask[b][l]) continue;
                x = beat_data[b][16*l +: 16];
                g = (b >= MAXB) ? '1 : IW'(b * LANES + l);
                e.empty = 1'b0;
`ifdef VPU_FP_MAX_REDUCE_NAN_EN
                if (nan_seen) continue;
                if (is_nan(x)) begin
                    nan_seen = 1;
                    e.val    = 16'h7FC0;
                    e.idx    = g;
                    continue;
                end
`endif
                if (!found || (mode ? (rank(x) < best) : (rank(x) > best))) begin
                    found = 1;
                    best  = rank(x);
                    e.val = x;
                    e.idx = g;
                end
            end
        end
        return e;
    endfunction

    // ---------------- drivers ----------------
    task automatic send_beats();
        for (int b = 0; b < nbeats; b++) begin
            in_valid = 1'b1;
            in_data  = beat_data[b];
            in_mask  = beat_mask[b];
            in_last  = (b == nbeats - 1);
            in_mode  = (b == 0 || !flip_mode) ? mode : ~mode;
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL send_ready beat %0d: in_ready=%b want 1", b, in_ready);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_mask  = '0;
        in_data  = '0;
    endtask

    task automatic wait_out();
        obs_lat = 0;
        while (out_valid !== 1'b1 && obs_lat < 20) begin
            @(posedge clk); #1;
            obs_lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL after_handshake: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({in_ready, out_valid, out_data, out_idx, out_empty, out_ovf} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: rdy=%b vld=%b data=%h idx=%h empty=%b ovf=%b want all 0",
                     in_ready, out_valid, out_data, out_idx, out_empty, out_ovf);
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release_early: in_ready=%b want 0", in_ready);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_first_edge: in_ready=%b want 1", in_ready);
        end
    endtask

    task automatic test_directed_max();
        nbeats = 1; mode = 1'b0; flip_mode = 1'b0;
        beat_data[0] = {16'h0000, 16'hBF80, 16'h4000, 16'h3F80};
        beat_mask[0] = 4'hF;
        send_beats();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL dmax_early_valid: out_valid=%b want 0", out_valid);
        end
        wait_out();
        n_cmp++;
        if (obs_lat !== 2) begin
            n_err++;
            $display("FAIL dmax_latency: got %0d edges want 2", obs_lat);
        end
        n_cmp++;
        if (out_data !== 16'h4000 || out_idx !== 4'd1 || out_empty !== 1'b0 || out_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL dmax_result: data=%h idx=%0d empty=%b ovf=%b want 4000/1/0/0",
                     out_data, out_idx, out_empty, out_ovf);
        end
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL dmax_ready_in_out: in_ready=%b want 0", in_ready);
        end
        consume();
    endtask

    task automatic test_min_mode_latch();
        nbeats = 2; mode = 1'b1; flip_mode = 1'b1;
        beat_data[0] = {16'h4080, 16'h4040, 16'h4000, 16'h3F80};
        beat_data[1] = {16'h3F80, 16'hBF80, 16'h3F80, 16'h3F80};
        beat_mask[0] = 4'hF;
        beat_mask[1] = 4'hF;
        send_beats();
        wait_out();
        n_cmp++;
        if (out_data !== 16'hBF80 || out_idx !== 4'd6 || obs_lat !== 2) begin
            n_err++;
            $display("FAIL min_latch: data=%h idx=%0d lat=%0d want BF80/6/2", out_data, out_idx, obs_lat);
        end
        consume();
    endtask

    task automatic test_zero_tie();
        nbeats = 1; mode = 1'b0; flip_mode = 1'b0;
        beat_data[0] = {16'h0000, 16'h0000, 16'h0000, 16'h8000};
        beat_mask[0] = 4'h3;
        send_beats();
        wait_out();
        n_cmp++;
        if (out_data !== 16'h0000 || out_idx !== 4'd1) begin
            n_err++;
            $display("FAIL zero_max: data=%h idx=%0d want 0000/1", out_data, out_idx);
        end
        consume();
        mode = 1'b1;
        send_beats();
        wait_out();
        n_cmp++;
        if (out_data !== 16'h8000 || out_idx !== 4'd0) begin
            n_err++;
            $display("FAIL zero_min: data=%h idx=%0d want 8000/0", out_data, out_idx);
        end
        consume();
        nbeats = 2; mode = 1'b0;
        beat_data[0] = {16'h4000, 16'h3F80, 16'h0000, 16'h8000};
        beat_data[1] = {16'h3F80, 16'h3F80, 16'h4000, 16'h3F00};
        beat_mask[0] = 4'hF;
        beat_mask[1] = 4'hF;
        send_beats();
        wait_out();
        n_cmp++;
        if (out_data !== 16'h4000 || out_idx !== 4'd3) begin
            n_err++;
            $display("FAIL tie_low_idx: data=%h idx=%0d want 4000/3", out_data, out_idx);
        end
        consume();
    endtask

    task automatic test_empty_hold();
        nbeats = 3; mode = 1'b0; flip_mode = 1'b0;
        for (int b = 0; b < 3; b++) begin
            beat_data[b] = {16'h4000, 16'h4000, 16'h4000, 16'h4000};
            beat_mask[b] = 4'h0;
        end
        send_beats();
        wait_out();
        for (int c = 0; c < 5; c++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== 16'hFF80 || out_idx !== 4'd0 ||
                out_empty !== 1'b1 || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL empty_hold cyc %0d: vld=%b data=%h idx=%0d empty=%b rdy=%b want 1/FF80/0/1/0",
                         c, out_valid, out_data, out_idx, out_empty, in_ready);
            end
            @(posedge clk); #1;
        end
        consume();
        mode = 1'b1; nbeats = 1;
        send_beats();
        wait_out();
        n_cmp++;
        if (out_data !== 16'h7F80 || out_empty !== 1'b1 || out_idx !== 4'd0) begin
            n_err++;
            $display("FAIL empty_min: data=%h empty=%b idx=%0d want 7F80/1/0", out_data, out_empty, out_idx);
        end
        consume();
    endtask

    task automatic test_overflow();
        nbeats = 6; mode = 1'b0; flip_mode = 1'b0;
        for (int b = 0; b < 5; b++) begin
            beat_data[b] = {16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80};
            beat_mask[b] = 4'hF;
        end
        beat_data[5] = {16'h3F80, 16'h4100, 16'h3F80, 16'h3F80};
        beat_mask[5] = 4'hF;
        send_beats();
        wait_out();
        n_cmp++;
        if (out_data !== 16'h4100 || out_idx !== 4'hF || out_ovf !== 1'b1 || out_empty !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_winner: data=%h idx=%h ovf=%b empty=%b want 4100/F/1/0",
                     out_data, out_idx, out_ovf, out_empty);
        end
        consume();
    endtask

    task automatic test_reset_mid_stream();
        int seen;
        in_valid = 1'b1; in_last = 1'b0; in_mode = 1'b0; in_mask = 4'hF;
        in_data  = {16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00};
        repeat (2) begin @(posedge clk); #1; end
        in_valid = 1'b0; in_mask = 4'h0;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_async: in_ready=%b out_valid=%b want 0/0", in_ready, out_valid);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL midreset_no_output: out_valid seen %0d cycles want 0", seen);
        end
        nbeats = 1; mode = 1'b0; flip_mode = 1'b0;
        beat_data[0] = {16'h3F80, 16'h3F00, 16'h3E80, 16'h3F40};
        beat_mask[0] = 4'hF;
        send_beats();
        wait_out();
        n_cmp++;
        if (out_data !== 16'h3F80 || out_idx !== 4'd3 || out_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_fresh: data=%h idx=%0d ovf=%b want 3F80/3/0", out_data, out_idx, out_ovf);
        end
        consume();
    endtask

    task automatic test_nan();
        logic [15:0] want;
        nbeats = 1; mode = 1'b0; flip_mode = 1'b0;
        beat_data[0] = {16'h3F00, 16'h7FC1, 16'h4000, 16'h3F80};
        beat_mask[0] = 4'hF;
`ifdef VPU_FP_MAX_REDUCE_NAN_EN
        want = 16'h7FC0;
`else
        want = 16'h7FC1;
`endif
        send_beats();
        wait_out();
        n_cmp++;
        if (out_data !== want || out_idx !== 4'd2) begin
            n_err++;
            $display("FAIL nan: data=%h idx=%0d want %h/2", out_data, out_idx, want);
        end
        consume();
    endtask

    task automatic test_random();
        logic [15:0] pal [8];
        exp_t        e;
        pal[0] = 16'h0000; pal[1] = 16'h8000; pal[2] = 16'h3F80; pal[3] = 16'hBF80;
        pal[4] = 16'h7F80; pal[5] = 16'hFF80; pal[6] = 16'h7FC1; pal[7] = 16'h4000;
        for (int it = 0; it < 60; it++) begin
            nbeats    = $urandom_range(1, 6);
            mode      = 1'($urandom_range(0, 1));
            flip_mode = 1'($urandom_range(0, 1));
            for (int b = 0; b < nbeats; b++) begin
                beat_mask[b] = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
                for (int l = 0; l < LANES; l++)
                    beat_data[b][16*l +: 16] = ($urandom_range(0, 1) == 0)
                                             ? pal[$urandom_range(0, 7)] : 16'($urandom);
            end
            e = model();
            send_beats();
            wait_out();
            n_cmp++;
            if (out_data !== e.val || out_idx !== e.idx || out_empty !== e.empty ||
                out_ovf !== e.ovf || obs_lat !== 2) begin
                n_err++;
                $display("FAIL rand it %0d: data=%h idx=%h empty=%b ovf=%b lat=%0d want %h/%h/%b/%b/2",
                         it, out_data, out_idx, out_empty, out_ovf, obs_lat,
                         e.val, e.idx, e.empty, e.ovf);
            end
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            consume();
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mask = '0;
        in_last = 1'b0; in_mode = 1'b0; out_ready = 1'b0;
        test_reset();
        test_directed_max();
        test_min_mode_latch();
        test_zero_tie();
        test_empty_hold();
        test_overflow();
        test_reset_mid_stream();
        test_nan();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
